instr_issue_ctrl: RTL and testbench

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

---
 rtl/instr_issue_ctrl.sv | 111 +++++++++++
 tb/tb_instr_issue_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: fetches a program from a registered-read buffer
// and issues it one instruction at a time over a request/response handshake.
module instr_issue_ctrl #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_150_0,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [AW-1:0] rdaddress,
  input  logic [31:0]   r_in,
  output logic          req_vaild,
  input  logic          req_ready,
  output logic [31:0]   req_data,
  input  logic          rsp_vaild,
  output logic          rsp_ready,
  output logic [AW:0]   issued_cnt,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic          tx_sel
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] ERR      = 3'd5;

  logic [2:0]    state_reg;
  logic [AW:0]   len_reg;
  logic          fetch_phase_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [AW:0]   issued_inc;

  assign issued_inc = issued_cnt + 1'b1;

  // Status outputs decode straight from the state so reset clears them at once.
  assign req_vaild   = (state_reg == ISSUE);
  assign busy        = (state_reg == FETCH) || (state_reg == ISSUE) || (state_reg == WAIT_RSP);
  assign done        = (state_reg == DONE);
  assign timeout_err = (state_reg == ERR);
  assign tx_sel      = (state_reg != IDLE);

  always_ff @(posedge clk_150_0 or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      len_reg         <= '0;
      fetch_phase_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
      rdaddress       <= '0;
      issued_cnt      <= '0;
      req_data        <= '0;
      rsp_ready       <= 1'b0;
    end else begin
      rsp_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg         <= prog_len;
            rdaddress       <= '0;
            issued_cnt      <= '0;
            fetch_phase_reg <= 1'b0;
            state_reg       <= (prog_len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          // First cycle presents the address, second sees the RAM output.
          if (fetch_phase_reg) begin
            fetch_phase_reg <= 1'b0;
            req_data        <= r_in;
            state_reg       <= ISSUE;
          end else begin
            fetch_phase_reg <= 1'b1;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_vaild) begin
            rsp_ready  <= 1'b1;
            issued_cnt <= issued_inc;
            if (issued_inc == len_reg) begin
              state_reg <= DONE;
            end else begin
              rdaddress <= rdaddress + 1'b1;
              state_reg <= FETCH;
            end
          end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
            state_reg <= ERR;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        DONE, ERR: begin
          if (!start) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Randomized bench for instr_issue_ctrl: a program RAM model, random handshake
// timing, and a transaction-level reference of what each run must produce.
module tb_instr_issue_ctrl;

  localparam int AW      = 4;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1 << AW;

  logic          clk_150_0 = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic [AW:0]   prog_len  = '0;
  logic [AW-1:0] rdaddress;
  logic [31:0]   r_in      = '0;
  logic          req_vaild;
  logic          req_ready = 1'b0;
  logic [31:0]   req_data;
  logic          rsp_vaild = 1'b0;
  logic          rsp_ready;
  logic [AW:0]   issued_cnt;
  logic          busy, done, timeout_err, tx_sel;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [DEPTH];

  instr_issue_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_150_0  (clk_150_0),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .rdaddress  (rdaddress),
    .r_in       (r_in),
    .req_vaild  (req_vaild),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .rsp_vaild  (rsp_vaild),
    .rsp_ready  (rsp_ready),
    .issued_cnt (issued_cnt),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .tx_sel     (tx_sel)
  );

  always #5 clk_150_0 = ~clk_150_0;

  // Program buffer with one cycle of read latency.
  always @(posedge clk_150_0) r_in <= mem[rdaddress];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_150_0);
    #1;
  endtask

  // One complete run. lose_idx names the instruction whose response never
  // arrives (-1 for none); stall_lo/hi bound how long each request is withheld.
  task automatic run_prog(input int len, input bit drop_start,
                          input int stall_lo, input int stall_hi, input int lose_idx);
    int issued, since_fetch, wait_cyc, delay, stall, exp_addr;
    bit waiting, finished, erred;
    logic pre_v, pre_rdy, pre_rsp;
    logic [31:0] held;
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    issued = 0; since_fetch = 0; wait_cyc = 0; delay = 0;
    waiting = 0; finished = 0; erred = 0; held = '0;
    stall = $urandom_range(stall_lo, stall_hi);
    prog_len  = (AW+1)'(len);
    start     = 1'b1;
    req_ready = 1'b0;
    rsp_vaild = 1'b0;
    tick();
    prog_len = (AW+1)'($urandom);
    if (len == 0) begin
      finished = 1;
      check_eq("zero_len_vaild", req_vaild, 1'b0);
    end
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      if (req_vaild) req_ready = (stall == 0);
      else           req_ready = 1'($urandom_range(0, 1));
      if (waiting) rsp_vaild = (wait_cyc == delay);
      else         rsp_vaild = 1'($urandom_range(0, 1));
      pre_v   = req_vaild;
      pre_rdy = req_ready;
      pre_rsp = waiting && rsp_vaild;
      if (drop_start && cyc == 3) start = 1'b0;
      tick();
      since_fetch++;
      check_eq("rsp_ready", rsp_ready, pre_rsp);
      if (pre_v && pre_rdy) begin
        check_eq("vaild_drop", req_vaild, 1'b0);
        waiting  = 1;
        wait_cyc = 0;
        delay    = (issued == lose_idx) ? TIMEOUT + 5 : $urandom_range(0, TIMEOUT - 1);
        stall    = $urandom_range(stall_lo, stall_hi);
      end else if (pre_v) begin
        check_eq("vaild_hold", req_vaild, 1'b1);
        check_eq("data_hold", req_data, held);
        stall--;
      end else if (pre_rsp) begin
        waiting = 0;
        issued++;
        check_eq("issued_cnt", issued_cnt, issued);
        if (issued == len) finished = 1;
        else since_fetch = 0;
      end else if (waiting) begin
        wait_cyc++;
        if (wait_cyc == TIMEOUT) begin
          check_eq("tmo_err", timeout_err, 1'b1);
          check_eq("tmo_busy", busy, 1'b0);
          check_eq("tmo_tx_sel", tx_sel, 1'b1);
          finished = 1;
          erred    = 1;
        end else begin
          check_eq("no_tmo_yet", timeout_err, 1'b0);
        end
      end
      if (!pre_v && req_vaild) begin
        check_eq("fetch_latency", since_fetch, 2);
        check_eq("issue_addr", rdaddress, issued % DEPTH);
        check_eq("issue_data", req_data, mem[issued % DEPTH]);
        held = req_data;
      end
      if (!finished) begin
        check_eq("run_busy", busy, 1'b1);
        check_eq("run_tx_sel", tx_sel, 1'b1);
      end
    end
    check_eq("run_finished", finished, 1'b1);
    exp_addr = (len == 0) ? 0 : (len - 1) % DEPTH;
    if (!erred) begin
      check_eq("end_done", done, 1'b1);
      check_eq("end_busy", busy, 1'b0);
      check_eq("end_issued", issued_cnt, len);
      check_eq("end_addr", rdaddress, exp_addr);
    end
    // Stray handshake inputs while parked must change nothing.
    req_ready = 1'b1;
    rsp_vaild = 1'b1;
    if (start) begin
      repeat ($urandom_range(1, 3)) begin
        tick();
        check_eq("park_done", done, !erred);
        check_eq("park_err", timeout_err, erred);
        check_eq("park_issued", issued_cnt, erred ? issued : len);
        check_eq("park_vaild", req_vaild, 1'b0);
      end
    end
    start = 1'b0;
    tick();
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_err", timeout_err, 1'b0);
    check_eq("idle_tx_sel", tx_sel, 1'b0);
    req_ready = 1'b0;
    rsp_vaild = 1'b0;
  endtask

  initial begin
    bit found;
    repeat (2) tick();
    check_eq("rst_vaild", req_vaild, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_sel", tx_sel, 1'b0);
    check_eq("rst_addr", rdaddress, 0);
    check_eq("rst_data", req_data, 0);
    reset = 1'b1;
    tick();
    check_eq("post_rst_tx_sel", tx_sel, 1'b0);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_cnt", issued_cnt, 0);

    run_prog(3, 0, 0, 0, -1);
    run_prog(3, 0, 5, 5, -1);
    run_prog(0, 0, 0, 0, -1);
    run_prog(2, 0, 0, 1, 1);
    run_prog(DEPTH, 0, 0, 2, -1);
    run_prog(4, 1, 0, 2, -1);
    for (int r = 0; r < 10; r++)
      run_prog($urandom_range(0, DEPTH), 1'($urandom_range(0, 1)), 0, 3,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);

    // Reset pulse while a request is being presented.
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    prog_len  = 5;
    start     = 1'b1;
    req_ready = 1'b0;
    found     = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      found = req_vaild;
    end
    check_eq("reach_issue", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_vaild", req_vaild, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_tx_sel", tx_sel, 1'b0);
    check_eq("arst_data", req_data, 0);
    check_eq("arst_addr", rdaddress, 0);
    check_eq("arst_cnt", issued_cnt, 0);
    check_eq("arst_rsp_ready", rsp_ready, 1'b0);
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_eq("rel_tx_sel", tx_sel, 1'b0);
    check_eq("rel_busy", busy, 1'b0);
    run_prog(4, 0, 0, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
